// File: rtl/barrel_pixel_fetch.sv
// Small first-word-fall-through FIFO used for the tag and pixel-data queues.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: none; the caller guarantees no push when full and no pop when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
endmodule

// Turns barrel-warp source coordinates into frame-buffer reads and an in-order pixel stream.
// Latency: out-of-frame accept -> pix_tvalid 2 cycles; in-frame = grant cycle + memory latency + 1.
// Backpressure: mem_ready drops while a read awaits grant or DEPTH pixels are in flight.
module barrel_pixel_fetch #(
    parameter int               H_RES  = 1280,
    parameter int               V_RES  = 720,
    parameter int               ADDR_W = 20,
    parameter int               PIX_W  = 24,
    parameter int               DEPTH  = 8,
    parameter logic [PIX_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       x_in,
    input  logic [11:0]       y_in,
    input  logic              addr_vld,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_req,
    input  logic              rd_gnt,
    input  logic [PIX_W-1:0]  rd_data,
    input  logic              rd_dvld,
    output logic [PIX_W-1:0]  pix_tdata,
    output logic              pix_tvalid,
    input  logic              pix_tready
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [12:0]   H_LIM   = 13'(H_RES);
    localparam logic [12:0]   V_LIM   = 13'(V_RES);

    typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;
    req_state_t req_state;
    req_state_t req_state_d;

    logic              accept;
    logic              oob;
    logic              gnt;
    logic              oob_pend;
    logic              dvld_ok;
    logic              pix_hs;
    logic [ADDR_W-1:0] addr_calc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     inflight_d;
    logic [CW-1:0]     pend_rd;
    logic              tag_empty;
    logic              tag_head;
    logic              dat_empty;
    logic [PIX_W-1:0]  dat_head;

    assign accept    = addr_vld && mem_ready;
    assign oob       = ({1'b0, x_in} >= H_LIM) || ({1'b0, y_in} >= V_LIM);
    assign addr_calc = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(x_in);
    assign rd_req    = (req_state == REQ_WAIT);
    assign gnt       = rd_req && rd_gnt;
    // Read data arriving with nothing outstanding (e.g. a response to a pre-reset request) is dropped.
    assign dvld_ok   = rd_dvld && (pend_rd != '0);

    always_comb begin
        req_state_d = req_state;
        case (req_state)
            REQ_IDLE: if (accept && !oob) req_state_d = REQ_WAIT;
            REQ_WAIT: if (rd_gnt) req_state_d = REQ_IDLE;
            default:  req_state_d = REQ_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight;
        if (accept && !pix_hs) begin
            inflight_d = inflight + CW'(1);
        end else if (!accept && pix_hs) begin
            inflight_d = inflight - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_state <= REQ_IDLE;
            rd_addr   <= '0;
        end else begin
            req_state <= req_state_d;
            if (accept && !oob) begin
                rd_addr <= addr_calc;
            end
        end
    end

    // mem_ready is registered from next-state values so it reads 0 throughout reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight  <= '0;
            pend_rd   <= '0;
            oob_pend  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            inflight  <= inflight_d;
            mem_ready <= (req_state_d == REQ_IDLE) && (inflight_d < DEPTH_C);
            oob_pend  <= accept && oob;
            if (gnt && !dvld_ok) begin
                pend_rd <= pend_rd + CW'(1);
            end else if (!gnt && dvld_ok) begin
                pend_rd <= pend_rd - CW'(1);
            end
        end
    end

    // Grant and out-of-frame tag pushes never coincide: a pending request blocks new accepts.
    fifo #(.W(1), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (gnt || oob_pend),
        .push_dat (gnt),
        .pop_vld  (pix_hs),
        .pop_dat  (tag_head),
        .empty    (tag_empty)
    );

    fifo #(.W(PIX_W), .DEPTH(DEPTH)) u_dat_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (dvld_ok),
        .push_dat (rd_data),
        .pop_vld  (pix_hs && tag_head),
        .pop_dat  (dat_head),
        .empty    (dat_empty)
    );

    assign pix_tvalid = !tag_empty && (!tag_head || !dat_empty);
    assign pix_tdata  = !pix_tvalid ? '0 : (tag_head ? dat_head : FILL);
    assign pix_hs     = pix_tvalid && pix_tready;
endmodule

// File: tb/tb_barrel_pixel_fetch.sv
// Bench for barrel_pixel_fetch: directed scenarios plus random traffic against an in-order pixel model.
module tb_barrel_pixel_fetch;
    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int D  = 8;
    localparam int NS = 4096;
    localparam int NEVER = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] x_in = '0;
    logic [11:0] y_in = '0;
    logic        addr_vld = 1'b0;
    logic        mem_ready;
    logic [19:0] rd_addr;
    logic        rd_req;
    logic        rd_gnt = 1'b0;
    logic [23:0] rd_data = '0;
    logic        rd_dvld = 1'b0;
    logic [23:0] pix_tdata;
    logic        pix_tvalid;
    logic        pix_tready = 1'b0;

    always #5 clk = ~clk;

    barrel_pixel_fetch #(
        .H_RES(H), .V_RES(V), .ADDR_W(20), .PIX_W(24), .DEPTH(D), .FILL(24'h0)
    ) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .addr_vld(addr_vld),
        .mem_ready(mem_ready), .rd_addr(rd_addr), .rd_req(rd_req), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_dvld(rd_dvld), .pix_tdata(pix_tdata),
        .pix_tvalid(pix_tvalid), .pix_tready(pix_tready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: every accepted coordinate is one entry; it may leave once its pixel is available.
    typedef struct {
        int          due;
        logic [23:0] d;
    } resp_t;

    int          cyc = 0;
    logic [23:0] e_dat [NS];
    int          e_avail [NS];
    int          head = 0;
    int          tail = 0;
    bit          busy = 0;
    int          busy_seq = 0;
    int          busy_addr = 0;
    bit          fresh = 1;
    int          n_acc = 0;
    int          n_out = 0;
    int          pendq [$];
    resp_t       respq [$];
    logic [23:0] patq [$];
    logic [23:0] outlog [$];

    int lat_min = 1, lat_max = 1, gnt_wait = 0, gnt_pct = 100, rdy_pct = 100, stray_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory and sink behaviour, driven just after each active edge.
    int    age = 0;
    resp_t r_m;
    always @(posedge clk) begin
        #1;
        if (rd_req && !reset) begin
            rd_gnt = (age >= gnt_wait) && ($urandom_range(0, 99) < gnt_pct);
            age++;
        end else begin
            rd_gnt = 1'b0;
            age = 0;
        end
        rd_dvld = 1'b0;
        rd_data = 24'($urandom);
        if (stray_n > 0) begin
            rd_dvld = 1'b1;
            stray_n--;
        end else if (respq.size() > 0 && respq[0].due <= cyc) begin
            r_m = respq.pop_front();
            rd_dvld = 1'b1;
            rd_data = r_m.d;
        end
        pix_tready = ($urandom_range(0, 99) < rdy_pct);
    end

    // Compare process: checks outputs mid-cycle, then folds in this cycle's events.
    bit          ev_c;
    int          s_c;
    int          due_c;
    logic [23:0] d_c;
    resp_t       r_c;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_mem_ready", mem_ready, 0);
            chk("rst_rd_req", rd_req, 0);
            chk("rst_pix_tvalid", pix_tvalid, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_pix_tdata", pix_tdata, 0);
            head = tail;
            busy = 0;
            pendq.delete();
            respq.delete();
            fresh = 1;
        end else begin
            ev_c = (head != tail) && (e_avail[head % NS] <= cyc);
            chk("mem_ready", mem_ready, !fresh && !busy && (tail - head < D));
            chk("rd_req", rd_req, busy);
            if (busy) chk("rd_addr", rd_addr, busy_addr);
            chk("pix_tvalid", pix_tvalid, ev_c);
            if (ev_c) chk("pix_tdata", pix_tdata, e_dat[head % NS]);
            fresh = 0;

            if (pix_tvalid && pix_tready && head != tail) begin
                outlog.push_back(pix_tdata);
                head++;
                n_out++;
            end
            if (rd_dvld && pendq.size() > 0) begin
                s_c = pendq.pop_front();
                e_avail[s_c % NS] = cyc + 1;
            end
            if (rd_req && rd_gnt && busy) begin
                d_c = (patq.size() > 0) ? patq.pop_front() : 24'($urandom);
                e_dat[busy_seq % NS] = d_c;
                pendq.push_back(busy_seq);
                due_c = cyc + $urandom_range(lat_min, lat_max);
                if (respq.size() > 0 && due_c <= respq[$].due) due_c = respq[$].due + 1;
                r_c.due = due_c;
                r_c.d = d_c;
                respq.push_back(r_c);
                busy = 0;
            end
            if (addr_vld && mem_ready) begin
                s_c = tail;
                tail++;
                n_acc++;
                e_dat[s_c % NS] = 24'h0;
                e_avail[s_c % NS] = NEVER;
                if (x_in >= H || y_in >= V) begin
                    e_avail[s_c % NS] = cyc + 2;
                end else begin
                    busy = 1;
                    busy_seq = s_c;
                    busy_addr = int'(y_in) * H + int'(x_in);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int y);
        bit ok;
        ok = 0;
        addr_vld = 1'b1;
        x_in = 12'(x);
        y_in = 12'(y);
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = mem_ready;
            @(posedge clk);
            #1;
        end
        addr_vld = 1'b0;
        x_in = 12'($urandom);
        y_in = 12'($urandom);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && head != tail; i++) step(1);
        chk("drain_empty", tail - head, 0);
    endtask

    int t3x [4] = '{1280, 0, 4095, 1279};
    int t3y [4] = '{0, 720, 4095, 720};
    int lat;
    int acc0;
    int out0;
    int rx;
    int ry;

    initial begin
        // 1: reset and release
        step(10);
        reset = 1'b0;
        chk("t1_ready_release", mem_ready, 0);
        chk("t1_tvalid_release", pix_tvalid, 0);
        step(1);
        chk("t1_ready_next", mem_ready, 1);
        chk("t1_tvalid_next", pix_tvalid, 0);

        // 2: single in-frame read, 3-cycle memory
        lat_min = 3; lat_max = 3;
        patq.push_back(24'hABCDEF);
        outlog.delete();
        send(5, 2);
        chk("t2_rd_req", rd_req, 1);
        chk("t2_rd_addr", rd_addr, 2565);
        step(1);
        chk("t2_req_drop", rd_req, 0);
        lat = 1;
        while (!pix_tvalid && lat < 30) begin
            step(1);
            lat++;
        end
        chk("t2_latency", lat, 4);
        chk("t2_data", pix_tdata, 24'hABCDEF);
        drain();
        chk("t2_out_count", outlog.size(), 1);

        // 3: out-of-frame coordinates give FILL two cycles after accept
        for (int i = 0; i < 4; i++) begin
            send(t3x[i], t3y[i]);
            chk("t3_no_req", rd_req, 0);
            chk("t3_tvalid_c1", pix_tvalid, 0);
            step(1);
            chk("t3_tvalid_c2", pix_tvalid, 1);
            chk("t3_fill", pix_tdata, 0);
        end
        drain();

        // 4: fill up DEPTH entries with the sink stalled
        rdy_pct = 0;
        step(1);
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < D; i++) send(1300 + i, i);
        chk("t4_accepts", n_acc - acc0, D);
        addr_vld = 1'b1;
        x_in = 12'd2000;
        y_in = 12'd5;
        for (int i = 0; i < 5; i++) begin
            chk("t4_full", mem_ready, 0);
            step(1);
        end
        rdy_pct = 100;
        send(2000, 5);
        drain();
        chk("t4_outputs", n_out - out0, D + 1);

        // 5: delayed grant, mixed order
        gnt_wait = 4;
        lat_min = 2; lat_max = 2;
        patq.push_back(24'h111111);
        patq.push_back(24'h222222);
        outlog.delete();
        send(10, 10);
        send(1280, 5);
        send(1279, 719);
        chk("t5_addr_max", rd_addr, 921599);
        drain();
        chk("t5_count", outlog.size(), 3);
        if (outlog.size() == 3) begin
            chk("t5_first", outlog[0], 24'h111111);
            chk("t5_second", outlog[1], 24'h0);
            chk("t5_third", outlog[2], 24'h222222);
        end

        // 6: reset with reads pending, then stray read data
        gnt_wait = 0;
        lat_min = 40; lat_max = 40;
        for (int i = 0; i < 3; i++) send(100 + i, 7);
        step(2);
        chk("t6_pending", tail - head, 3);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        stray_n = 3;
        step(10);
        chk("t6_tvalid", pix_tvalid, 0);
        chk("t6_ready", mem_ready, 1);

        // 7: random traffic
        lat_min = 1; lat_max = 5;
        gnt_wait = 1; gnt_pct = 60; rdy_pct = 70;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0: begin rx = H - 1; ry = $urandom_range(0, V); end
                1: begin rx = $urandom_range(H - 1, H); ry = V - 1; end
                2: begin rx = 4095; ry = $urandom_range(0, 4095); end
                default: begin rx = $urandom_range(0, 1400); ry = $urandom_range(0, 800); end
            endcase
            send(rx, ry);
            step($urandom_range(0, 2));
        end
        rdy_pct = 100;
        gnt_pct = 100;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
